decoder_scan_sequencer: RTL and testbench
=========================================

// Module: decoder_scan_sequencer
// PURPOSE
//   Upstream driver for the 3-to-8 decoder. Steps a 3-bit select code {a,b,c} through the enabled channels of an 8-bit mask.
//   Holds each code for a programmable dwell time, in single-sweep or continuous mode.
//   The decoder consumes {a,b,c} directly; code_valid qualifies the decoded one-hot lines.
// PARAMETERS
//   DWELL_W  8  width of dwell count; each channel is held dwell+1 cycles
// PORTS
//   clk         in   1        single clock; all state updates on posedge
//   rst         in   1        synchronous reset, active-high
//   start       in   1        pulse: begin a sweep (ignored while busy)
//   stop        in   1        abort the sweep; return to IDLE
//   continuous  in   1        1 = wrap and repeat; 0 = single sweep; sampled at start
//   dwell       in   DWELL_W  hold time per channel minus 1; sampled at start
//   ch_mask     in   8        channel enables, bit i = code i; sampled at start
//   a,b,c       out  1 each   registered select code, a = MSB, c = LSB
//   code_valid  out  1        1 while {a,b,c} addresses an enabled channel in dwell
//   busy        out  1        1 in any state other than IDLE
//   done        out  1        1-cycle pulse at the end of a single sweep
//   wrap        out  1        1-cycle pulse when continuous mode restarts at the lowest channel
// BEHAVIOUR
//   Reset: state IDLE; {a,b,c}=3'b000; code_valid, busy, done and wrap all 0; latched mask, dwell and mode cleared.
//   States: IDLE, DWELL. A next-channel search runs combinationally; there is no gap cycle between channels.
//   IDLE + start, stop=0, ch_mask!=0:
//     - Latch mask, dwell and continuous.
//     - On the next cycle: {a,b,c} = lowest set mask bit, dwell counter = dwell, code_valid=1, busy=1, state DWELL.
//   IDLE + start with ch_mask==0: stay in IDLE; done pulses on the next cycle; code_valid stays 0.
//   DWELL: the counter decrements each cycle. When it is 0:
//     - Higher enabled channel exists: load that code and reload the counter.
//     - No higher channel, continuous=1: load the lowest enabled code, reload the counter, pulse wrap for 1 cycle.
//     - No higher channel, continuous=0: go to IDLE; code_valid=0, busy=0, done=1 for 1 cycle; {a,b,c} keeps the last code.
//   Latency: start at cycle N gives the first code valid at N+1. Channel k occupies exactly dwell+1 cycles.
//   stop (any state): next cycle state IDLE; code_valid=0, busy=0; no done and no wrap pulse; {a,b,c} keeps its value.
//   Simultaneous events:
//     - stop beats start.
//     - stop beats end-of-sweep (no done).
//     - start while busy is ignored.
//   Mask with a single bit in continuous mode: the same code is held, and wrap pulses every dwell+1 cycles.
//   Changes to ch_mask, dwell or continuous during a sweep have no effect until the next start.
//   rst mid-sweep: immediate return to the reset values on that clock edge.
// CONFIGURATION
//   SCAN_PAUSE_EN defined:
//     - Adds input port pause (1 bit), placed after stop.
//     - While pause=1 in DWELL: the dwell counter and code freeze; code_valid stays 1.
//     - stop and rst still act immediately; pause has no effect in IDLE.
//   SCAN_PAUSE_EN undefined: no pause port; the counter always decrements.
// TESTING
//   1. Reset held for 2 cycles -> a,b,c=0; code_valid, busy, done, wrap all 0.
//   2. mask=8'hFF, dwell=0, continuous=0, start -> codes 0..7, one per cycle on cycles 1..8; done pulses on cycle 9.
//   3. mask=8'b1010_0100, dwell=2, continuous=1 -> codes 2,5,7, each for 3 cycles; then wrap pulses together with code 2; repeats.
//   4. mask=8'hFF, dwell=3, stop asserted in the second cycle of code 1 -> next cycle IDLE, code_valid=0, done never asserted.
//   5. mask=8'h00 with start -> one done pulse, code_valid stays 0; start during a sweep -> sequence unaffected.
//   6. SCAN_PAUSE_EN: mask=8'h03, dwell=1, pause high for 4 cycles during code 0 -> code 0 held for 6 cycles total, then code 1.

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
// Select-code scan sequencer for a 3-to-8 decoder: walks the enabled channels of a mask with a programmable dwell.
// Optional feature macro: SCAN_PAUSE_EN adds a 'pause' input that freezes the dwell counter and code.
module decoder_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
`ifdef SCAN_PAUSE_EN
  input  logic               pause,
`endif
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         ch_mask,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               code_valid,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t             state_q, state_d;
  logic [2:0]         code_q, code_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [7:0]         mask_q, mask_d;
  logic               cont_q, cont_d;
  logic               code_valid_q, code_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic               pause_active;
  logic [3:0]         next_hit;

`ifdef SCAN_PAUSE_EN
  assign pause_active = pause;
`else
  assign pause_active = 1'b0;
`endif

  function automatic logic [2:0] lowest_code(input logic [7:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Returns {found, code} for the lowest enabled channel strictly above cur.
  function automatic logic [3:0] next_code(input logic [7:0] m, input logic [2:0] cur);
    logic       found;
    logic [2:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) begin
        found = 1'b1;
        idx   = 3'(i);
      end
    end
    return {found, idx};
  endfunction

  assign next_hit = next_code(mask_q, code_q);

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    dwell_d      = dwell_q;
    mask_d       = mask_q;
    cont_d       = cont_q;
    code_valid_d = code_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    wrap_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (ch_mask == 8'h00) begin
            done_d = 1'b1;
          end else begin
            mask_d       = ch_mask;
            dwell_d      = dwell;
            cont_d       = continuous;
            code_d       = lowest_code(ch_mask);
            cnt_d        = dwell;
            code_valid_d = 1'b1;
            busy_d       = 1'b1;
            state_d      = DWELL;
          end
        end
      end
      DWELL: begin
        if (stop) begin
          code_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (!pause_active) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (next_hit[3]) begin
            code_d = next_hit[2:0];
            cnt_d  = dwell_q;
          end else if (cont_q) begin
            code_d = lowest_code(mask_q);
            cnt_d  = dwell_q;
            wrap_d = 1'b1;
          end else begin
            // End of a single sweep: the last code stays on the select lines.
            code_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      code_q       <= '0;
      cnt_q        <= '0;
      dwell_q      <= '0;
      mask_q       <= '0;
      cont_q       <= 1'b0;
      code_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      dwell_q      <= dwell_d;
      mask_q       <= mask_d;
      cont_q       <= cont_d;
      code_valid_q <= code_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wrap_q       <= wrap_d;
    end
  end

  assign a          = code_q[2];
  assign b          = code_q[1];
  assign c          = code_q[0];
  assign code_valid = code_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench for decoder_scan_sequencer: a channel-list model checked every cycle plus directed literal checks.
// Pause scenarios are exercised when SCAN_PAUSE_EN is defined.
module tb_decoder_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic       continuous;
  logic [7:0] dwell;
  logic [7:0] ch_mask;
  logic       a, b, c;
  logic       code_valid, busy, done, wrap;
  logic [2:0] code_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  assign code_out = {a, b, c};

  decoder_scan_sequencer #(.DWELL_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
`ifdef SCAN_PAUSE_EN
    .pause      (pause),
`endif
    .continuous (continuous),
    .dwell      (dwell),
    .ch_mask    (ch_mask),
    .a          (a),
    .b          (b),
    .c          (c),
    .code_valid (code_valid),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: at start the enabled channels become an ordered list that is walked with a per-entry hold count.
  int         m_list[8];
  int         m_n = 0, m_pos = 0, m_left = 0, m_dwell = 0;
  bit         m_cont = 0;
  logic [2:0] m_code = '0;
  logic       m_cv = 0, m_busy = 0, m_done = 0, m_wrap = 0;
  bit         m_pause;

  always @(posedge clk) begin
`ifdef SCAN_PAUSE_EN
    m_pause = (pause === 1'b1);
`else
    m_pause = 0;
`endif
    m_done = 0;
    m_wrap = 0;
    if (rst) begin
      m_busy = 0; m_cv = 0; m_code = '0;
      m_n = 0; m_pos = 0; m_left = 0; m_dwell = 0; m_cont = 0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        if (ch_mask == 8'h00) begin
          m_done = 1;
        end else begin
          m_n = 0;
          for (int i = 0; i < 8; i++) begin
            if (ch_mask[i]) begin
              m_list[m_n] = i;
              m_n++;
            end
          end
          m_dwell = int'(dwell);
          m_cont  = continuous;
          m_pos   = 0;
          m_left  = m_dwell;
          m_code  = 3'(m_list[0]);
          m_cv    = 1;
          m_busy  = 1;
        end
      end
    end else if (stop) begin
      m_busy = 0; m_cv = 0;
    end else if (m_pause) begin
      m_left = m_left;
    end else if (m_left > 0) begin
      m_left--;
    end else if (m_pos + 1 < m_n) begin
      m_pos++;
      m_code = 3'(m_list[m_pos]);
      m_left = m_dwell;
    end else if (m_cont) begin
      m_pos  = 0;
      m_code = 3'(m_list[0]);
      m_left = m_dwell;
      m_wrap = 1;
    end else begin
      m_busy = 0; m_cv = 0; m_done = 1;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model_code",  {5'b0, code_out},   {5'b0, m_code});
      checkOutput("model_valid", {7'b0, code_valid}, {7'b0, m_cv});
      checkOutput("model_busy",  {7'b0, busy},       {7'b0, m_busy});
      checkOutput("model_done",  {7'b0, done},       {7'b0, m_done});
      checkOutput("model_wrap",  {7'b0, wrap},       {7'b0, m_wrap});
    end
  end

  task automatic applyStimulus(input logic st, input logic sp, input logic cont,
                               input logic [7:0] dw, input logic [7:0] mask);
    start      = st;
    stop       = sp;
    continuous = cont;
    dwell      = dw;
    ch_mask    = mask;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doStop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  logic [2:0] pat3 [3];

  initial begin
    pat3[0] = 3'd2; pat3[1] = 3'd5; pat3[2] = 3'd7;
    rst   = 1'b1;
    pause = 1'b0;
    applyStimulus(0, 0, 0, 8'h00, 8'h00);

    tick(2);
    cmp_en = 1;
    checkOutput("rst_code",  {5'b0, code_out}, 8'd0);
    checkOutput("rst_valid", {7'b0, code_valid}, 8'd0);
    checkOutput("rst_busy",  {7'b0, busy}, 8'd0);
    checkOutput("rst_done",  {7'b0, done}, 8'd0);
    checkOutput("rst_wrap",  {7'b0, wrap}, 8'd0);
    rst = 1'b0;
    tick(1);

    // Full mask, dwell 0, single sweep: one code per cycle, then done.
    applyStimulus(1, 0, 0, 8'd0, 8'hFF);
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("t2_code",  {5'b0, code_out}, 8'(i));
      checkOutput("t2_valid", {7'b0, code_valid}, 8'd1);
      tick(1);
    end
    checkOutput("t2_done",      {7'b0, done}, 8'd1);
    checkOutput("t2_end_valid", {7'b0, code_valid}, 8'd0);
    checkOutput("t2_end_code",  {5'b0, code_out}, 8'd7);
    tick(1);
    checkOutput("t2_done_off",  {7'b0, done}, 8'd0);

    // Sparse mask, dwell 2, continuous; inputs changed mid-sweep must be ignored.
    applyStimulus(1, 0, 1, 8'd2, 8'b1010_0100);
    tick(1);
    applyStimulus(0, 0, 0, 8'd0, 8'hFF);
    for (int j = 0; j < 18; j++) begin
      checkOutput("t3_code", {5'b0, code_out}, {5'b0, pat3[(j / 3) % 3]});
      checkOutput("t3_wrap", {7'b0, wrap}, (j == 9) ? 8'd1 : 8'd0);
      tick(1);
    end
    doStop();
    checkOutput("t3_stop_busy", {7'b0, busy}, 8'd0);
    checkOutput("t3_stop_code", {5'b0, code_out}, 8'd2);
    checkOutput("t3_stop_wrap", {7'b0, wrap}, 8'd0);
    tick(1);

    // Stop in the second cycle of code 1 (dwell 3): no done afterwards.
    applyStimulus(1, 0, 0, 8'd3, 8'hFF);
    tick(1);
    start = 1'b0;
    tick(5);
    checkOutput("t4_pre_code", {5'b0, code_out}, 8'd1);
    doStop();
    checkOutput("t4_valid", {7'b0, code_valid}, 8'd0);
    checkOutput("t4_busy",  {7'b0, busy}, 8'd0);
    checkOutput("t4_code",  {5'b0, code_out}, 8'd1);
    for (int k = 0; k < 6; k++) begin
      checkOutput("t4_no_done", {7'b0, done}, 8'd0);
      tick(1);
    end

    // Empty mask: single done pulse, nothing valid.
    applyStimulus(1, 0, 0, 8'd0, 8'h00);
    tick(1);
    start = 1'b0;
    checkOutput("t5_done",  {7'b0, done}, 8'd1);
    checkOutput("t5_valid", {7'b0, code_valid}, 8'd0);
    checkOutput("t5_busy",  {7'b0, busy}, 8'd0);
    tick(1);
    checkOutput("t5_done_off", {7'b0, done}, 8'd0);

    // Start while busy is ignored.
    applyStimulus(1, 0, 0, 8'd1, 8'h06);
    tick(1);
    start = 1'b0;
    checkOutput("t5b_code0", {5'b0, code_out}, 8'd1);
    tick(1);
    applyStimulus(1, 0, 1, 8'd0, 8'h80);
    checkOutput("t5b_code1", {5'b0, code_out}, 8'd1);
    tick(1);
    start = 1'b0;
    checkOutput("t5b_code2", {5'b0, code_out}, 8'd2);
    tick(1);
    checkOutput("t5b_code3", {5'b0, code_out}, 8'd2);
    tick(1);
    checkOutput("t5b_done", {7'b0, done}, 8'd1);
    checkOutput("t5b_busy", {7'b0, busy}, 8'd0);
    tick(1);

    // Single channel in continuous mode: wrap every dwell+1 cycles.
    applyStimulus(1, 0, 1, 8'd1, 8'h10);
    tick(1);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("t7_code", {5'b0, code_out}, 8'd4);
      checkOutput("t7_wrap", {7'b0, wrap}, (k == 2 || k == 4) ? 8'd1 : 8'd0);
      tick(1);
    end
    doStop();
    tick(1);

    // Stop beats start.
    applyStimulus(1, 1, 0, 8'd0, 8'hFF);
    tick(1);
    applyStimulus(0, 0, 0, 8'd0, 8'hFF);
    checkOutput("t8_busy", {7'b0, busy}, 8'd0);
    checkOutput("t8_done", {7'b0, done}, 8'd0);
    tick(1);

    // Stop beats end of sweep.
    applyStimulus(1, 0, 0, 8'd0, 8'h01);
    tick(1);
    start = 1'b0;
    checkOutput("t9_code", {5'b0, code_out}, 8'd0);
    doStop();
    checkOutput("t9_done", {7'b0, done}, 8'd0);
    checkOutput("t9_busy", {7'b0, busy}, 8'd0);
    tick(1);

    // Reset mid-sweep.
    applyStimulus(1, 0, 1, 8'd2, 8'hF0);
    tick(1);
    start = 1'b0;
    checkOutput("t10_code", {5'b0, code_out}, 8'd4);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("t10_rst_code",  {5'b0, code_out}, 8'd0);
    checkOutput("t10_rst_busy",  {7'b0, busy}, 8'd0);
    checkOutput("t10_rst_valid", {7'b0, code_valid}, 8'd0);
    tick(2);
    checkOutput("t10_idle", {7'b0, busy}, 8'd0);

`ifdef SCAN_PAUSE_EN
    // Pause for 4 cycles during code 0 stretches it to 6 cycles.
    applyStimulus(1, 0, 0, 8'd1, 8'h03);
    tick(1);
    start = 1'b0;
    pause = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) pause = 1'b0;
      checkOutput("t6_code0", {5'b0, code_out}, 8'd0);
      checkOutput("t6_valid", {7'b0, code_valid}, 8'd1);
      tick(1);
    end
    checkOutput("t6_code1", {5'b0, code_out}, 8'd1);
    tick(4);
    // Pause has no effect in IDLE.
    pause = 1'b1;
    applyStimulus(1, 0, 0, 8'd0, 8'h08);
    tick(1);
    start = 1'b0;
    checkOutput("t6_idle_start", {5'b0, code_out}, 8'd3);
    doStop();
    pause = 1'b0;
    tick(1);
`endif

    tick(2);
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
